lpc_operand_packer: RTL and testbench

- Producer side of the precision-scalable signed multiplier interface (i_x, i_y, mode; mac_out).
- Accepts a stream of signed (x, y) element pairs at the configured precision (2, 4 or 8 bit) over a valid/ready handshake.
- Packs the elements into 8-bit lane words and drives them to the multiplier with the matching mode code.
- Carries a valid/last tag pipeline matched to multiplier latency, so the result consumer knows which mac_out samples are real.

---
 rtl/lpc_pkg.sv | 37 +++
 rtl/lpc_tag_delay.sv | 40 ++++
 rtl/lpc_operand_packer.sv | 129 ++++++++++++
 tb/tb_lpc_operand_packer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - mode codes and lane helpers shared by the operand packer and result side
package lpc_pkg;

  localparam logic [1:0] MODE_2B  = 2'b00;
  localparam logic [1:0] MODE_4B  = 2'b01;
  localparam logic [1:0] MODE_8B  = 2'b10;
  localparam logic [1:0] MODE_OFF = 2'b11;

  localparam int MUL_LATENCY_DEF = 2;

  function automatic logic [2:0] lanes_of(input logic [1:0] mode);
    case (mode)
      MODE_2B: lanes_of = 3'd4;
      MODE_4B: lanes_of = 3'd2;
      default: lanes_of = 3'd1;
    endcase
  endfunction

  function automatic logic [3:0] lane_width(input logic [1:0] mode);
    case (mode)
      MODE_2B: lane_width = 4'd2;
      MODE_4B: lane_width = 4'd4;
      default: lane_width = 4'd8;
    endcase
  endfunction

  // Truncates an element to the lane width and moves it to its lane position.
  function automatic logic [7:0] lane_insert(input logic [1:0] mode, input logic [1:0] lane,
                                             input logic [7:0] elem);
    logic [7:0] mask;
    logic [3:0] sh;
    mask = 8'hFF >> (4'd8 - lane_width(mode));
    sh   = {2'b00, lane} * lane_width(mode);
    lane_insert = (elem & mask) << sh;
  endfunction

endpackage

// File: rtl/lpc_tag_delay.sv
// rtl/lpc_tag_delay.sv - fixed-depth valid/last shift register aligned to multiplier latency
module lpc_tag_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;

  always_comb begin
    valid_d    = valid_q;
    last_d     = last_q;
    valid_d[0] = in_valid;
    last_d[0]  = in_last;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/lpc_operand_packer.sv
// rtl/lpc_operand_packer.sv - packs signed element pairs into lane words for the precision-scalable multiplier
module lpc_operand_packer
  import lpc_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cfg_mode,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_x,
  input  logic [7:0] s_y,
  input  logic       s_last,
  input  logic       m_ready,
  output logic       m_valid,
  output logic [7:0] m_x,
  output logic [7:0] m_y,
  output logic [1:0] m_mode,
  output logic       res_valid,
  output logic       res_last
);

  logic [1:0] lane_cnt_q, lane_cnt_d;
  logic [7:0] part_x_q, part_x_d;
  logic [7:0] part_y_q, part_y_d;
  logic [1:0] word_mode_q, word_mode_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_x_q, m_x_d;
  logic [7:0] m_y_q, m_y_d;
  logic [1:0] m_mode_q, m_mode_d;
  logic       last_q, last_d;

  logic       stall, accept, fire, closing, last_lane;
  logic [1:0] eff_mode;
  logic [7:0] merged_x, merged_y;

  always_comb begin
    stall     = m_valid_q && !m_ready;
    fire      = m_valid_q && m_ready;
    s_ready   = ((cfg_mode != MODE_OFF) || (lane_cnt_q != 2'd0)) && !stall;
    accept    = s_valid && s_ready;
    // The first element of a word decides its precision; later cfg changes wait for the next word.
    eff_mode  = (lane_cnt_q == 2'd0) ? cfg_mode : word_mode_q;
    last_lane = ({1'b0, lane_cnt_q} == (lanes_of(eff_mode) - 3'd1));
    closing   = accept && (last_lane || s_last);
    merged_x  = part_x_q | lane_insert(eff_mode, lane_cnt_q, s_x);
    merged_y  = part_y_q | lane_insert(eff_mode, lane_cnt_q, s_y);

    lane_cnt_d  = lane_cnt_q;
    part_x_d    = part_x_q;
    part_y_d    = part_y_q;
    word_mode_d = word_mode_q;
    m_valid_d   = m_valid_q;
    m_x_d       = m_x_q;
    m_y_d       = m_y_q;
    m_mode_d    = m_mode_q;
    last_d      = last_q;

    if (accept) begin
      word_mode_d = eff_mode;
      if (closing) begin
        lane_cnt_d = 2'd0;
        part_x_d   = 8'h00;
        part_y_d   = 8'h00;
      end else begin
        lane_cnt_d = lane_cnt_q + 2'd1;
        part_x_d   = merged_x;
        part_y_d   = merged_y;
      end
    end

    // Bubbles drive zero operands in the off mode so mac_out reads zero.
    if (closing) begin
      m_valid_d = 1'b1;
      m_x_d     = merged_x;
      m_y_d     = merged_y;
      m_mode_d  = eff_mode;
      last_d    = s_last;
    end else if (fire) begin
      m_valid_d = 1'b0;
      m_x_d     = 8'h00;
      m_y_d     = 8'h00;
      m_mode_d  = MODE_OFF;
      last_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_cnt_q  <= 2'd0;
      part_x_q    <= 8'h00;
      part_y_q    <= 8'h00;
      word_mode_q <= MODE_OFF;
      m_valid_q   <= 1'b0;
      m_x_q       <= 8'h00;
      m_y_q       <= 8'h00;
      m_mode_q    <= MODE_OFF;
      last_q      <= 1'b0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      part_x_q    <= part_x_d;
      part_y_q    <= part_y_d;
      word_mode_q <= word_mode_d;
      m_valid_q   <= m_valid_d;
      m_x_q       <= m_x_d;
      m_y_q       <= m_y_d;
      m_mode_q    <= m_mode_d;
      last_q      <= last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_x     = m_x_q;
  assign m_y     = m_y_q;
  assign m_mode  = m_mode_q;

  lpc_tag_delay #(
    .DEPTH(MUL_LATENCY)
  ) u_tag_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fire),
    .in_last  (fire && last_q),
    .out_valid(res_valid),
    .out_last (res_last)
  );

endmodule

// File: tb/tb_lpc_operand_packer.sv
// tb/tb_lpc_operand_packer.sv - directed and randomized checks of the operand packer against a word-level model
module tb_lpc_operand_packer;
  import lpc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cfg_mode;
  logic       s_valid, s_ready, s_last;
  logic [7:0] s_x, s_y;
  logic       m_ready, m_valid;
  logic [7:0] m_x, m_y;
  logic [1:0] m_mode;
  logic       res_valid, res_last;

  int tests = 0;
  int fails = 0;

  logic [7:0] cx[$];
  logic [7:0] cy[$];
  logic [1:0] cmode;
  logic       e_mv, e_last;
  logic [7:0] e_mx, e_my;
  logic [1:0] e_mm;
  logic [1:0] hist[$];
  int         res_count;

  always #5 clk = ~clk;

  lpc_operand_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_mode (cfg_mode),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_x      (s_x),
    .s_y      (s_y),
    .s_last   (s_last),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_x      (m_x),
    .m_y      (m_y),
    .m_mode   (m_mode),
    .res_valid(res_valid),
    .res_last (res_last)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lanes_m(input logic [1:0] m);
    if (m == 2'b00) return 4;
    if (m == 2'b01) return 2;
    return 1;
  endfunction

  task automatic model_clear();
    cx.delete();
    cy.delete();
    cmode  = 2'b11;
    e_mv   = 1'b0;
    e_mx   = 8'h00;
    e_my   = 8'h00;
    e_mm   = 2'b11;
    e_last = 1'b0;
    hist   = '{2'b00, 2'b00};
  endtask

  // One clock: drive inputs, predict handshake, advance the model, compare all outputs.
  task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y, input logic l,
                      input logic [1:0] cfg, input logic mr);
    logic       exp_rdy, acc, fire;
    logic [1:0] r;
    int         n, w, px, py;
    s_valid  = v;
    s_x      = x;
    s_y      = y;
    s_last   = l;
    cfg_mode = cfg;
    m_ready  = mr;
    #1;
    exp_rdy = ((cfg != 2'b11) || (cx.size() != 0)) && !(e_mv && !mr);
    chk("s_ready", {7'b0, s_ready}, {7'b0, exp_rdy});
    acc  = v && exp_rdy;
    fire = e_mv && mr;
    @(posedge clk);
    #1;
    hist.push_back({fire, fire && e_last});
    void'(hist.pop_front());
    r = hist[0];
    if (acc) begin
      if (cx.size() == 0) cmode = cfg;
      cx.push_back(x);
      cy.push_back(y);
    end
    n = lanes_m(cmode);
    if (acc && (cx.size() == n || l)) begin
      w  = 8 / n;
      px = 0;
      py = 0;
      for (int k = 0; k < cx.size(); k++) begin
        px += (int'(cx[k]) % (1 << w)) * (1 << (k * w));
        py += (int'(cy[k]) % (1 << w)) * (1 << (k * w));
      end
      e_mv   = 1'b1;
      e_mx   = px[7:0];
      e_my   = py[7:0];
      e_mm   = cmode;
      e_last = l;
      cx.delete();
      cy.delete();
    end else if (fire) begin
      e_mv   = 1'b0;
      e_mx   = 8'h00;
      e_my   = 8'h00;
      e_mm   = 2'b11;
      e_last = 1'b0;
    end
    if (res_valid) res_count++;
    chk("m_valid", {7'b0, m_valid}, {7'b0, e_mv});
    chk("m_x", m_x, e_mx);
    chk("m_y", m_y, e_my);
    chk("m_mode", {6'b0, m_mode}, {6'b0, e_mm});
    chk("res_valid", {7'b0, res_valid}, {7'b0, r[1]});
    chk("res_last", {7'b0, res_last}, {7'b0, r[0]});
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_x      = 8'h00;
    s_y      = 8'h00;
    cfg_mode = 2'b00;
    m_ready  = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_m_valid", {7'b0, m_valid}, 8'h00);
    chk("rst_m_x", m_x, 8'h00);
    chk("rst_m_y", m_y, 8'h00);
    chk("rst_m_mode", {6'b0, m_mode}, 8'h03);
    chk("rst_res_valid", {7'b0, res_valid}, 8'h00);
    chk("rst_res_last", {7'b0, res_last}, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int cycles, input logic [1:0] cfg);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 8'h00, 1'b0, cfg, 1'b1);
  endtask

  initial begin
    do_reset();
    idle(2, 2'b10);

    // 8-bit lane: one word per pair, tag two cycles after presentation
    step(1'b1, 8'hF3, 8'h05, 1'b0, 2'b10, 1'b1);
    chk("tp1_mx", m_x, 8'hF3);
    chk("tp1_my", m_y, 8'h05);
    chk("tp1_mode", {6'b0, m_mode}, 8'h02);
    step(1'b0, 8'h00, 8'h00, 1'b0, 2'b10, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b0, 2'b10, 1'b1);
    chk("tp1_res_valid", {7'b0, res_valid}, 8'h01);

    // 4-bit lanes
    step(1'b1, 8'h03, 8'h01, 1'b0, 2'b01, 1'b1);
    step(1'b1, 8'h0A, 8'h02, 1'b0, 2'b01, 1'b1);
    chk("tp2_mx", m_x, 8'hA3);
    chk("tp2_my", m_y, 8'h21);
    idle(3, 2'b01);

    // 2-bit lanes, full word with last
    step(1'b1, 8'h01, 8'h03, 1'b0, 2'b00, 1'b1);
    step(1'b1, 8'h02, 8'h03, 1'b0, 2'b00, 1'b1);
    step(1'b1, 8'h03, 8'h03, 1'b0, 2'b00, 1'b1);
    step(1'b1, 8'h00, 8'h03, 1'b1, 2'b00, 1'b1);
    chk("tp3_mx", m_x, 8'h39);
    chk("tp3_my", m_y, 8'hFF);
    idle(2, 2'b00);
    chk("tp3_res_last", {7'b0, res_last}, 8'h01);

    // 2-bit lanes, short word closed by last
    step(1'b1, 8'h03, 8'h01, 1'b0, 2'b00, 1'b1);
    step(1'b1, 8'h01, 8'h01, 1'b1, 2'b00, 1'b1);
    chk("tp4_mx", m_x, 8'h07);
    chk("tp4_my", m_y, 8'h05);
    idle(3, 2'b00);

    // stall for three cycles then release: exactly one tag
    res_count = 0;
    step(1'b1, 8'h5A, 8'hC3, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 8'h22, 1'b0, 2'b10, 1'b0);
    chk("tp5_hold_mx", m_x, 8'h5A);
    idle(4, 2'b10);
    chk("tp5_one_res", res_count[7:0], 8'h01);

    // mode change mid-word is ignored until the word closes
    step(1'b1, 8'h04, 8'h06, 1'b0, 2'b01, 1'b1);
    step(1'b1, 8'h07, 8'h08, 1'b0, 2'b10, 1'b1);
    chk("tp6_mode", {6'b0, m_mode}, 8'h01);
    chk("tp6_mx", m_x, 8'h74);

    // word in flight plus partial word, then reset: nothing survives
    step(1'b1, 8'h09, 8'h09, 1'b0, 2'b10, 1'b1);
    step(1'b1, 8'h01, 8'h01, 1'b0, 2'b01, 1'b1);
    do_reset();
    res_count = 0;
    idle(4, 2'b11);
    chk("tp7_no_res", res_count[7:0], 8'h00);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] c;
      c = (($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 4) == 0), c, 1'($urandom_range(0, 3) != 0));
    end
    idle(4, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
